glb_rdport_arb: RTL

- Shares one GLB read port between NUM_REQ requesters, such as the PE array, pooling unit and DRAM writeback.
- Arbitrates address requests round-robin and forwards the winner's address to the GLB read-port handshake.
- Records the winner ID in an in-order outstanding FIFO and steers each returning read beat back to the requester that issued it.
- Sits between the requester engines and one GLB read port. The port is configured with RdPortUseAddr=1.

---
 rtl/glb_rdport_arb.sv | 137 +++++++++++++
 1 files changed

// File: rtl/glb_rdport_arb.sv
// glb_rdport_arb
//   Shares one in-order GLB read port between NUM_REQ requester engines.
//   Address requests are arbitrated round-robin and passed straight through
//   to the GLB. The winner's ID is pushed into an in-order ID FIFO. Each
//   returning beat is steered back to the ID at the FIFO head. Both paths
//   are purely combinational, so no latency is added.
//
// Ports
//   clk            clock
//   rst_n          synchronous reset, ACTIVE-HIGH despite the name
//   ReqAddrVld     per-requester address valid
//   ReqAddr        per-requester address; slice i belongs to requester i
//   ReqAddrRdy     per-requester address accept (one-hot or zero)
//   ReqDat         read data, broadcast to all requesters
//   ReqDatVld      one-hot data valid, steered to the head ID
//   ReqDatRdy      per-requester data ready (only the head's bit matters)
//   RdPortAddr     address to the GLB read port
//   RdPortAddrVld  address valid to the GLB
//   RdPortAddrRdy  GLB address accept
//   RdPortDat      GLB read data
//   RdPortDatVld   GLB data valid
//   RdPortDatRdy   ready to the GLB
//   OutstdCnt      number of in-flight reads
//   OrphanErr      sticky flag: a beat arrived with nothing outstanding

module glb_rdport_arb #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 256,
  parameter int MAX_OUTSTD = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            ReqAddrVld,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0] ReqAddr,
  output logic [NUM_REQ-1:0]            ReqAddrRdy,
  output logic [DATA_WIDTH-1:0]         ReqDat,
  output logic [NUM_REQ-1:0]            ReqDatVld,
  input  logic [NUM_REQ-1:0]            ReqDatRdy,
  output logic [ADDR_WIDTH-1:0]         RdPortAddr,
  output logic                          RdPortAddrVld,
  input  logic                          RdPortAddrRdy,
  input  logic [DATA_WIDTH-1:0]         RdPortDat,
  input  logic                          RdPortDatVld,
  output logic                          RdPortDatRdy,
  output logic [$clog2(MAX_OUTSTD):0]   OutstdCnt,
  output logic                          OrphanErr
);

  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int FIFO_AW = $clog2(MAX_OUTSTD);
  localparam int CNT_W   = FIFO_AW + 1;

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gnt;
  logic [ID_W-1:0]    scan_idx;
  logic               no_gnt;

  logic [ID_W-1:0]    id_mem [MAX_OUTSTD];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [ID_W-1:0]    head;

  logic               full;
  logic               not_empty;
  logic               push;
  logic               pop;

  // Round-robin scan starting at ptr; first valid requester wins.
  always_comb begin
    gnt      = '0;
    no_gnt   = 1'b1;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (no_gnt && ReqAddrVld[scan_idx]) begin
        gnt    = scan_idx;
        no_gnt = 1'b0;
      end
    end
  end

  assign full      = (cnt == CNT_W'(MAX_OUTSTD));
  assign not_empty = (cnt != '0);
  assign head      = id_mem[rd_ptr];

  // Full blocks issue for the whole cycle, even if a pop frees a slot in the
  // same cycle; this keeps the valid path free of a data-side dependency.
  assign RdPortAddrVld = !rst_n && !no_gnt && !full;
  assign RdPortAddr    = ReqAddr[gnt*ADDR_WIDTH +: ADDR_WIDTH];
  assign push          = RdPortAddrVld && RdPortAddrRdy;

  always_comb begin
    ReqAddrRdy = '0;
    if (push) ReqAddrRdy[gnt] = 1'b1;
  end

  // Only the head requester can stall the GLB; others' ready is ignored.
  assign ReqDat       = RdPortDat;
  assign RdPortDatRdy = !rst_n && not_empty && ReqDatRdy[head];
  assign pop          = RdPortDatVld && RdPortDatRdy;

  always_comb begin
    ReqDatVld = '0;
    if (!rst_n && RdPortDatVld && not_empty) ReqDatVld[head] = 1'b1;
  end

  assign OutstdCnt = cnt;

  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr] <= gnt;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      ptr       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      OrphanErr <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        ptr    <= (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (RdPortDatVld && !not_empty) OrphanErr <= 1'b1;
    end
  end

endmodule
